pipe_result_buf: RTL and testbench

Result-side companion to the 3-stage arithmetic pipeline f = ((a+b)+(c-d))*d. The block sits directly downstream of that pipeline and consumes its registered output `f`. It carries a valid tag through a delay line matched to the pipeline latency, because the pipeline itself has no valid or stall. Each tagged result is captured into a small show-ahead FIFO with a ready/valid output. The block also keeps a saturating accumulator, a result count and a sticky overflow flag, since the upstream pipeline cannot be back-pressured.

---
 rtl/pipe_result_buf.sv | 106 ++++++++++
 tb/tb_pipe_result_buf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_buf.sv
// Result-side companion for the 3-stage pipeline f = ((a+b)+(c-d))*d.
// It delays a valid tag to match the pipeline, then buffers, sums and counts the tagged results.
module pipe_result_buf #(
   parameter int N     = 10,
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [N-1:0]             f,
   input  logic                     clr,
   output logic [N-1:0]             out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [2*N-1:0]           acc,
   output logic [15:0]              count,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);

   // Valid tag delay line; its last tap marks the cycle in which f belongs to a tagged operand set.
   logic [LAT-1:0] v;
   logic           cap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
      end else begin
         v[0] <= in_valid;
         for (int i = 1; i < LAT; i++) begin
            v[i] <= v[i-1];
         end
      end
   end

   assign cap = v[LAT-1];

   // Output handshake: a word transfers on every rising edge where out_valid and out_ready
   // are both high; out_valid never depends on out_ready, and out_data is stable while
   // out_valid is high and no transfer occurs.
   logic [N-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         empty;
   logic         full;
   logic         pop;
   logic         push;
   logic         drop;

   // The extra pointer bit separates full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && out_ready;
   assign push  = cap && (!full || pop);
   assign drop  = cap && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= f;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign out_data  = mem[rd_ptr[AW-1:0]];
   assign out_valid = !empty;
   assign level     = wr_ptr - rd_ptr;

   // Statistics follow the pipeline, so they update on every capture, dropped or not.
   logic [2*N:0] sum;
   assign sum = {1'b0, acc} + {{(N+1){1'b0}}, f};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (cap) begin
            acc   <= sum[2*N] ? {(2*N){1'b1}} : sum[2*N-1:0];
            count <= count + 16'd1;
         end
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_result_buf.sv
// Bench for pipe_result_buf: a stand-in upstream pipeline feeds f, and a queue-based
// reference model predicts the buffer, accumulator, count and overflow flag each cycle.
module tb_pipe_result_buf;

   localparam int N     = 10;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;
   localparam longint ACC_MAX = (64'd1 << (2*N)) - 1;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic [N-1:0]            f;
   logic                    clr;
   logic [N-1:0]            out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [$clog2(DEPTH):0]  level;
   logic [2*N-1:0]          acc;
   logic [15:0]             count;
   logic                    ovf;

   logic [N-1:0] a, b, c, d;
   logic [N-1:0] p0 = '0;
   logic [N-1:0] p1 = '0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int           due;
      logic [N-1:0] val;
   } op_t;

   op_t          pend[$];
   logic [N-1:0] exp_q[$];
   logic [N-1:0] mem_m [DEPTH];
   int           push_cnt;
   int           pop_cnt;
   int           edge_cnt;
   longint       acc_m;
   int           cnt_m;
   logic         ovf_m;

   pipe_result_buf #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .f         (f),
      .clr       (clr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .acc       (acc),
      .count     (count),
      .ovf       (ovf)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [N-1:0] calc(input logic [N-1:0] ia, ib, ic, id);
      logic [31:0] t;
      t = (32'(ia) + 32'(ib) + (32'(ic) - 32'(id))) * 32'(id);
      return t[N-1:0];
   endfunction

   // Upstream 3-stage pipeline stand-in: f is its registered output.
   always @(posedge clk) begin
      p0 <= calc(a, b, c, d);
      p1 <= p0;
      f  <= p1;
   end

   function automatic logic [N-1:0] rnd();
      return N'($urandom_range(0, (1 << N) - 1));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("acc", 64'(acc), acc_m);
      chk("count", 64'(count), 64'(cnt_m));
      chk("ovf", {63'd0, ovf}, {63'd0, ovf_m});
      if (exp_q.size() > 0) chk("out_data", 64'(out_data), 64'(exp_q[0]));
      else                  chk("out_data_stale", 64'(out_data), 64'(mem_m[pop_cnt % DEPTH]));
   endtask

   task automatic model_reset();
      pend.delete();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      push_cnt = 0;
      pop_cnt  = 0;
      acc_m    = 0;
      cnt_m    = 0;
      ovf_m    = 1'b0;
   endtask

   // driver + model: one clock edge per call, outputs checked 1 time unit after the edge
   task automatic step(input logic iv, input logic [N-1:0] ia, ib, ic, id,
                       input logic rdy, input logic cl);
      logic         cap_m;
      logic         pop_m;
      logic         push_m;
      logic [N-1:0] fv;
      int           e_next;
      in_valid  = iv;
      a = ia; b = ib; c = ic; d = id;
      out_ready = rdy;
      clr       = cl;
      e_next    = edge_cnt + 1;
      cap_m     = 1'b0;
      fv        = '0;
      if (pend.size() > 0 && pend[0].due == e_next) begin
         cap_m = 1'b1;
         fv    = pend[0].val;
         void'(pend.pop_front());
      end
      if (iv) pend.push_back('{due: e_next + LAT, val: calc(ia, ib, ic, id)});
      pop_m  = (exp_q.size() > 0) && rdy;
      push_m = cap_m && ((exp_q.size() < DEPTH) || pop_m);
      @(posedge clk);
      edge_cnt++;
      #1;
      if (pop_m) begin
         void'(exp_q.pop_front());
         pop_cnt++;
      end
      if (push_m) begin
         exp_q.push_back(fv);
         mem_m[push_cnt % DEPTH] = fv;
         push_cnt++;
      end
      if (cl) begin
         acc_m = 0;
         cnt_m = 0;
         ovf_m = 1'b0;
      end else begin
         if (cap_m) begin
            acc_m = (acc_m + longint'(fv) > ACC_MAX) ? ACC_MAX : acc_m + longint'(fv);
            cnt_m = (cnt_m + 1) & 16'hFFFF;
         end
         if (cap_m && !push_m) ovf_m = 1'b1;
      end
      check_all();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, rnd(), rnd(), rnd(), rnd(), rdy, 1'b0);
   endtask

   task automatic rand_op(input logic rdy, input logic cl);
      step(1'b1, rnd(), rnd(), rnd(), rnd(), rdy, cl);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      edge_cnt = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // single op: (3+4)+(10-2) = 15, times 2 = 30, visible three edges after the tag
      step(1'b1, 10'd3, 10'd4, 10'd10, 10'd2, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("single_early_valid", {63'd0, out_valid}, 64'd0);
      idle(1, 1'b0);
      chk("single_data", 64'(out_data), 64'd30);
      chk("single_acc", 64'(acc), 64'd30);
      chk("single_count", 64'(count), 64'd1);
      chk("single_level", 64'(level), 64'd1);
      idle(2, 1'b1);

      // burst of six with no consumer: first four kept, ovf set
      step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) rand_op(1'b0, 1'b0);
      idle(LAT, 1'b0);
      chk("burst_level", 64'(level), 64'(DEPTH));
      chk("burst_ovf", {63'd0, ovf}, 64'd1);
      chk("burst_count", 64'(count), 64'd6);
      idle(DEPTH + 2, 1'b1);
      chk("burst_drained", {63'd0, out_valid}, 64'd0);

      // fill, then stream with pops coinciding with every capture
      step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) rand_op(i >= DEPTH + LAT, 1'b0);
      chk("stream_level", 64'(level), 64'(DEPTH));
      chk("stream_ovf", {63'd0, ovf}, 64'd0);
      idle(LAT + DEPTH + 1, 1'b1);

      // clr on the capture edge: stats cleared, FIFO still written
      rand_op(1'b0, 1'b0);
      idle(LAT - 1, 1'b0);
      step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
      chk("clr_count", 64'(count), 64'd0);
      chk("clr_acc", 64'(acc), 64'd0);
      chk("clr_level", 64'(level), 64'd1);
      idle(2, 1'b1);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), rnd(), rnd(), rnd(), rnd(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      end
      idle(LAT + DEPTH + 1, 1'b1);

      // saturation: 1023 each capture, 1025 captures reach exactly 2^20-1
      step(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 1030; i++) step(1'b1, 10'd1023, 10'd0, 10'd1, 10'd1, 1'b1, 1'b0);
      idle(LAT, 1'b1);
      chk("sat_acc", 64'(acc), ACC_MAX);
      chk("sat_count", 64'(count), 64'd1030);

      // async reset while tags are in flight
      for (int i = 0; i < 5; i++) rand_op(1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_acc", 64'(acc), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      #2 rst = 1'b0;
      idle(LAT, 1'b1);
      chk("rst_no_capture", 64'(count), 64'd0);
      for (int i = 0; i < 4; i++) rand_op(1'b0, 1'b0);
      idle(LAT + 1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
